bsg_wormhole_packet_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter. Shares one wormhole output link between num_in_p flit sources, e.g. test-node clients feeding one router port.

---
 rtl/bsg_wormhole_packet_arbiter_pkg.sv | 16 +
 rtl/bsg_wormhole_packet_arbiter_if.sv | 28 ++
 rtl/bsg_wormhole_packet_arbiter_rr_pick.sv | 37 +++
 rtl/bsg_wormhole_packet_arbiter.sv | 136 +++++++++++++
 tb/tb_bsg_wormhole_packet_arbiter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/bsg_wormhole_packet_arbiter_pkg.sv
// Shared types and header-field helpers for the wormhole packet arbiter.
// Header layout: cord in the low bits, len directly above it.
package bsg_wormhole_arb_pkg;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_busy = 1'b1
    } arb_state_e;

    localparam int cord_lsb_lp = 0;

    function automatic int len_lsb(input int cord_width);
        return cord_lsb_lp + cord_width;
    endfunction

endpackage

// File: rtl/bsg_wormhole_packet_arbiter_if.sv
// Bundle of per-source flit inputs plus the shared output link of the arbiter.
// The slave modport is the arbiter side; the master modport drives sources and the sink.
interface bsg_wormhole_packet_arbiter_if #(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 32
);
    localparam int grant_width_lp = $clog2(num_in_p);

    logic [num_in_p-1:0]                   v_i;
    logic [num_in_p-1:0][flit_width_p-1:0] data_i;
    logic [num_in_p-1:0]                   yumi_o;
    logic                                  v_o;
    logic [flit_width_p-1:0]               data_o;
    logic                                  ready_and_i;
    logic [grant_width_lp-1:0]             grant_o;
    logic                                  busy_o;

    modport slave (
        input  v_i, data_i, ready_and_i,
        output yumi_o, v_o, data_o, grant_o, busy_o
    );

    modport master (
        output v_i, data_i, ready_and_i,
        input  yumi_o, v_o, data_o, grant_o, busy_o
    );

endinterface

// File: rtl/bsg_wormhole_packet_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of v_i at or above rr_ptr_i, wrapping.
// Wrap is computed against num_in_p so non-power-of-2 sizes never yield an out-of-range index.
module bsg_wormhole_arb_rr_pick #(
    parameter  int num_in_p = 2,
    localparam int ptr_w_lp = $clog2(num_in_p)
) (
    input  logic [num_in_p-1:0] v_i,
    input  logic [ptr_w_lp-1:0] rr_ptr_i,
    output logic [num_in_p-1:0] one_hot_o,
    output logic [ptr_w_lp-1:0] idx_o,
    output logic                any_v_o
);

    logic [ptr_w_lp:0]   sum;
    logic [ptr_w_lp-1:0] cand;

    always_comb begin
        one_hot_o = '0;
        idx_o     = rr_ptr_i;
        any_v_o   = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < num_in_p; k++) begin
            sum = {1'b0, rr_ptr_i} + (ptr_w_lp+1)'(k);
            if (sum >= (ptr_w_lp+1)'(num_in_p)) begin
                sum = sum - (ptr_w_lp+1)'(num_in_p);
            end
            cand = sum[ptr_w_lp-1:0];
            if (!any_v_o && v_i[cand]) begin
                any_v_o         = 1'b1;
                idx_o           = cand;
                one_hot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_wormhole_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one wormhole link among num_in_p sources.
// Optional per-source completed-packet counters: define BSG_WORMHOLE_ARB_PERF_EN.
module bsg_wormhole_packet_arbiter
    import bsg_wormhole_arb_pkg::*;
#(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    bsg_wormhole_packet_arbiter_if.slave    link
`ifdef BSG_WORMHOLE_ARB_PERF_EN
    ,
    output logic [num_in_p-1:0][31:0]       perf_pkts_o
`endif
);

    localparam int gw_lp      = $clog2(num_in_p);
    localparam int len_lsb_lp = len_lsb(cord_width_p);

    arb_state_e               state_q;
    logic [len_width_p-1:0]   cnt_q;
    logic [gw_lp-1:0]         rr_ptr_q;
    logic [gw_lp-1:0]         grant_q;

    logic [num_in_p-1:0]      pick_oh;
    logic [gw_lp-1:0]         pick_idx;
    logic                     pick_any;

    logic [gw_lp-1:0]         sel;
    logic [num_in_p-1:0]      sel_oh;
    logic [flit_width_p-1:0]  sel_data;
    logic [len_width_p-1:0]   hdr_len;
    logic                     v_sel;
    logic                     xfer;

    function automatic logic [gw_lp-1:0] rr_next(input logic [gw_lp-1:0] g);
        return (g == gw_lp'(num_in_p-1)) ? '0 : g + gw_lp'(1);
    endfunction

    bsg_wormhole_arb_rr_pick #(.num_in_p(num_in_p)) rr_pick (
        .v_i      (link.v_i),
        .rr_ptr_i (rr_ptr_q),
        .one_hot_o(pick_oh),
        .idx_o    (pick_idx),
        .any_v_o  (pick_any)
    );

    // Selection depends only on state and v_i, never on ready_and_i.
    always_comb begin
        sel_oh = '0;
        if (state_q == e_busy) begin
            sel         = grant_q;
            sel_oh[sel] = 1'b1;
        end else begin
            sel    = pick_any ? pick_idx : rr_ptr_q;
            sel_oh = pick_oh;
        end
    end

    assign sel_data = link.data_i[sel];
    assign hdr_len  = sel_data[len_lsb_lp +: len_width_p];
    assign v_sel    = reset_n_i & link.v_i[sel];
    assign xfer     = v_sel & link.ready_and_i;

    assign link.v_o     = v_sel;
    assign link.data_o  = sel_data;
    assign link.yumi_o  = xfer ? sel_oh : '0;
    assign link.grant_o = reset_n_i ? sel : '0;
    assign link.busy_o  = (state_q == e_busy);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            case (state_q)
                e_idle: begin
                    if (xfer) begin
                        if (hdr_len == '0) begin
                            rr_ptr_q <= rr_next(sel);
                        end else begin
                            state_q <= e_busy;
                            grant_q <= sel;
                            cnt_q   <= hdr_len;
                        end
                    end
                end
                e_busy: begin
                    if (xfer) begin
                        cnt_q <= cnt_q - len_width_p'(1);
                        if (cnt_q == len_width_p'(1)) begin
                            state_q  <= e_idle;
                            rr_ptr_q <= rr_next(grant_q);
                        end
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

`ifdef BSG_WORMHOLE_ARB_PERF_EN
    // A packet completes on its last flit: the header itself when len is zero.
    logic                       pkt_done;
    logic [num_in_p-1:0][31:0]  perf_q;
    logic [num_in_p-1:0][31:0]  perf_d;

    assign pkt_done = xfer & (((state_q == e_idle) & (hdr_len == '0)) |
                              ((state_q == e_busy) & (cnt_q == len_width_p'(1))));

    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < num_in_p; i++) begin
            if (pkt_done && sel_oh[i] && (perf_q[i] != 32'hFFFF_FFFF)) begin
                perf_d[i] = perf_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_pkts_o = perf_q;
`endif

endmodule

// File: tb/tb_bsg_wormhole_packet_arbiter.sv
// Directed bench for the wormhole packet arbiter with three sources (exercises non-power-of-2 wrap).
// Each step pushes its expected link state onto a scoreboard queue; the check pops and compares.
module tb_bsg_wormhole_packet_arbiter;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] data;
        logic [2:0]  yumi;
        logic [1:0]  grant;
        logic        busy;
    } exp_t;

    exp_t expQ[$];

    bsg_wormhole_packet_arbiter_if #(.num_in_p(3), .flit_width_p(32)) link();

`ifdef BSG_WORMHOLE_ARB_PERF_EN
    logic [2:0][31:0] perf;
`endif

    bsg_wormhole_packet_arbiter #(
        .num_in_p    (3),
        .flit_width_p(32),
        .cord_width_p(5),
        .len_width_p (4)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .link       (link)
`ifdef BSG_WORMHOLE_ARB_PERF_EN
        ,
        .perf_pkts_o(perf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flit layout: cord in [4:0], len in [8:5], unique tag above.
    function automatic logic [31:0] mkFlit(input int src, input int len, input int tag);
        return {23'(tag), 4'(len), 5'(src)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = expQ.pop_front();
            chk("v_o", 32'(link.v_o), 32'(e.v));
            chk("yumi_o", 32'(link.yumi_o), 32'(e.yumi));
            chk("grant_o", 32'(link.grant_o), 32'(e.grant));
            chk("busy_o", 32'(link.busy_o), 32'(e.busy));
            if (e.v) chk("data_o", link.data_o, e.data);
        end
    endtask

    // Drive one cycle of stimulus away from the rising edge and record what the link must show.
    task automatic applyStimulus(input logic rstn, input logic [2:0] v,
                                 input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                                 input logic rdy, input logic ev, input logic [2:0] ey,
                                 input logic [1:0] eg, input logic eb);
        exp_t e;
        @(negedge clk);
        reset_n          = rstn;
        link.v_i         = v;
        link.data_i[0]   = f0;
        link.data_i[1]   = f1;
        link.data_i[2]   = f2;
        link.ready_and_i = rdy;
        e.v     = ev;
        e.data  = (eg == 2'd0) ? f0 : (eg == 2'd1) ? f1 : f2;
        e.yumi  = ey;
        e.grant = eg;
        e.busy  = eb;
        expQ.push_back(e);
        #2;
        checkOutput();
    endtask

    initial begin
        reset_n          = 1'b0;
        link.v_i         = '0;
        link.data_i      = '0;
        link.ready_and_i = 1'b1;

        // Reset hold with both low sources requesting.
        applyStimulus(0, 3'b011, mkFlit(0,3,1), mkFlit(1,0,2), 0, 1, 0, 3'b000, 0, 0);
        applyStimulus(0, 3'b011, mkFlit(0,3,1), mkFlit(1,0,2), 0, 1, 0, 3'b000, 0, 0);

        // Lock: src0 len=3 packet goes out whole while src1 waits.
        applyStimulus(1, 3'b011, mkFlit(0,3,10), mkFlit(1,0,2), 0, 1, 1, 3'b001, 0, 0);
        applyStimulus(1, 3'b011, mkFlit(0,0,11), mkFlit(1,0,2), 0, 1, 1, 3'b001, 0, 1);
        applyStimulus(1, 3'b011, mkFlit(0,0,12), mkFlit(1,0,2), 0, 1, 1, 3'b001, 0, 1);
        applyStimulus(1, 3'b011, mkFlit(0,0,13), mkFlit(1,0,2), 0, 1, 1, 3'b001, 0, 1);
        applyStimulus(1, 3'b011, mkFlit(0,0,14), mkFlit(1,0,2), 0, 1, 1, 3'b010, 1, 0);

        // Backpressure mid-packet: rr_ptr=2, so src0 wins after wrap.
        applyStimulus(1, 3'b001, mkFlit(0,3,20), 0, 0, 1, 1, 3'b001, 0, 0);
        applyStimulus(1, 3'b001, mkFlit(0,0,21), 0, 0, 0, 1, 3'b000, 0, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,21), 0, 0, 1, 1, 3'b001, 0, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,22), 0, 0, 0, 1, 3'b000, 0, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,22), 0, 0, 1, 1, 3'b001, 0, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,23), 0, 0, 1, 1, 3'b001, 0, 1);
        applyStimulus(1, 3'b000, 0, 0, 0, 1, 0, 3'b000, 1, 0);

        // Stalled header takes no lock; arbitration moves on to src2.
        applyStimulus(1, 3'b010, 0, mkFlit(1,2,30), 0, 0, 1, 3'b000, 1, 0);
        applyStimulus(1, 3'b100, 0, 0, mkFlit(2,0,31), 1, 1, 3'b100, 2, 0);

        // Round-robin with wrap over single-flit packets.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 3'b111, mkFlit(0,0,40+i), mkFlit(1,0,50+i), mkFlit(2,0,60+i), 1,
                          1, 3'(1 << (i % 3)), 2'(i % 3), 0);
        end

        // Bubble: src1 drops valid mid-packet while src0 requests.
        applyStimulus(1, 3'b010, 0, mkFlit(1,3,70), 0, 1, 1, 3'b010, 1, 0);
        applyStimulus(1, 3'b011, mkFlit(0,0,80), mkFlit(1,0,71), 0, 1, 1, 3'b010, 1, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,80), 0, 0, 1, 0, 3'b000, 1, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,80), 0, 0, 1, 0, 3'b000, 1, 1);
        applyStimulus(1, 3'b011, mkFlit(0,0,80), mkFlit(1,0,72), 0, 1, 1, 3'b010, 1, 1);
        applyStimulus(1, 3'b010, 0, mkFlit(1,0,73), 0, 1, 1, 3'b010, 1, 1);
        applyStimulus(1, 3'b001, mkFlit(0,0,81), 0, 0, 1, 1, 3'b001, 0, 0);

        // Async reset after 2 of 5 flits of a src1 packet; checked before any rising edge.
        applyStimulus(1, 3'b010, 0, mkFlit(1,4,90), 0, 1, 1, 3'b010, 1, 0);
        applyStimulus(1, 3'b010, 0, mkFlit(1,0,91), 0, 1, 1, 3'b010, 1, 1);
        applyStimulus(0, 3'b010, 0, mkFlit(1,0,92), 0, 1, 0, 3'b000, 0, 0);
`ifdef BSG_WORMHOLE_ARB_PERF_EN
        chk("perf_src1_after_reset", perf[1], 32'd0);
        chk("perf_src0_after_reset", perf[0], 32'd0);
`endif
        applyStimulus(1, 3'b011, mkFlit(0,0,93), mkFlit(1,0,94), 0, 1, 1, 3'b001, 0, 0);
        applyStimulus(1, 3'b000, 0, 0, 0, 1, 0, 3'b000, 1, 0);
`ifdef BSG_WORMHOLE_ARB_PERF_EN
        chk("perf_src0_one_pkt", perf[0], 32'd1);
        chk("perf_src1_still_zero", perf[1], 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
